// File: rtl/instr_encoder.sv
// RV32I instruction encoder: a one-entry output register with a valid/ready handshake on each side.
// Illegal requests are consumed without producing output and are counted in a saturating err_count.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_name,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [7:0]  err_count,
  output logic [15:0] enc_count
);

  typedef enum logic [4:0] {
    N_ADD  = 5'd0,
    N_SUB  = 5'd1,
    N_AND  = 5'd2,
    N_OR   = 5'd3,
    N_ADDI = 5'd4,
    N_ANDI = 5'd5,
    N_ORI  = 5'd6,
    N_LW   = 5'd7,
    N_JALR = 5'd8,
    N_BEQ  = 5'd9,
    N_BNE  = 5'd10,
    N_JAL  = 5'd11,
    N_SW   = 5'd12
  } name_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic signed [31:0] simm;
  logic               i_ok;
  logic               b_ok;
  logic               j_ok;
  logic [31:0]        enc;
  logic               legal;
  logic               accept;
  logic [31:0]        next_addr;

  assign simm     = $signed(in_imm);
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Range checks are done on the full 32-bit signed immediate; B/J offsets must also be even.
  assign i_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign b_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !in_imm[0];
  assign j_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (name_e'(in_name))
      N_ADD:  begin enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R}; legal = 1'b1; end
      N_SUB:  begin enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R}; legal = 1'b1; end
      N_AND:  begin enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OP_R}; legal = 1'b1; end
      N_OR:   begin enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OP_R}; legal = 1'b1; end
      N_ADDI: begin enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IMM}; legal = i_ok; end
      N_ANDI: begin enc = {in_imm[11:0], in_rs1, 3'b111, in_rd, OP_IMM}; legal = i_ok; end
      N_ORI:  begin enc = {in_imm[11:0], in_rs1, 3'b110, in_rd, OP_IMM}; legal = i_ok; end
      N_LW:   begin enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LD};  legal = i_ok; end
      N_JALR: begin enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JR};  legal = i_ok; end
      N_SW: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_ST};
        legal = i_ok;
      end
      N_BEQ: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], OP_BR};
        legal = b_ok;
      end
      N_BNE: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001, in_imm[4:1], in_imm[11], OP_BR};
        legal = b_ok;
      end
      N_JAL: begin
        enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        legal = j_ok;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  // next_addr tracks the address of the next emitted word so rejects never advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      next_addr <= BASE_ADDR;
      err_count <= '0;
      enc_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (legal) begin
          out_valid <= 1'b1;
          out_instr <= enc;
          out_addr  <= next_addr;
          next_addr <= next_addr + 32'd4;
          enc_count <= enc_count + 16'd1;
        end else if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; BASE_ADDR is chosen near the top so out_addr wraps.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_name;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [7:0]  err_count;
  logic [15:0] enc_count;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_addr;
  logic [15:0] exp_enc;
  logic [7:0]  exp_err;
  logic [31:0] held;

  typedef struct packed {
    logic [4:0]  name;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_name   (in_name),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err_count (err_count),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; out_ready is left as the caller set it.
  task automatic send(input logic [4:0] name, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    in_valid = 1'b1;
    in_name  = name;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_addr"}, out_addr, exp_addr);
    exp_addr = exp_addr + 32'd4;
    exp_enc  = exp_enc + 16'd1;
    check({tag, "_enc"}, {16'b0, enc_count}, {16'b0, exp_enc});
  endtask

  task automatic expect_reject(input string tag);
    exp_err = exp_err + 8'd1;
    check({tag, "_novalid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_err"}, {24'b0, err_count}, {24'b0, exp_err});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_name = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = BASE; exp_enc = '0; exp_err = '0;

    tbl[0]  = {5'd1,  5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3};
    tbl[1]  = {5'd2,  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020F1B3};
    tbl[2]  = {5'd3,  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020E1B3};
    tbl[3]  = {5'd7,  5'd5, 5'd2, 5'd0, 32'd16,         32'h01012283};
    tbl[4]  = {5'd8,  5'd1, 5'd5, 5'd0, 32'd0,          32'h000280E7};
    tbl[5]  = {5'd10, 5'd0, 5'd1, 5'd2, 32'd4094,       32'h7E209FE3};
    tbl[6]  = {5'd4,  5'd5, 5'd0, 5'd0, 32'd2047,       32'h7FF00293};
    tbl[7]  = {5'd4,  5'd5, 5'd0, 5'd0, 32'hFFFF_F800,  32'h80000293};
    tbl[8]  = {5'd6,  5'd1, 5'd1, 5'd0, 32'd0,          32'h0000E093};
    tbl[9]  = {5'd11, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000,  32'h8000006F};
    tbl[10] = {5'd5,  5'd2, 5'd3, 5'd7, 32'hFFFF_FFFF,  32'hFFF1F113};

    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err", {24'b0, err_count}, 32'd0);
    check("rst_enc", {16'b0, enc_count}, 32'd0);
    rst = 1'b0;
    #1;

    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add", 32'h002081B3);

    send(5'd4, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    expect_word("addi_m1", 32'hFFF00293);
    send(5'd12, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("sw", 32'h0020A423);

    send(5'd9, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    expect_word("beq_m4", 32'hFE208EE3);
    send(5'd11, 5'd1, 5'd0, 5'd0, 32'd8);
    expect_word("jal_8_wrap", 32'h008000EF);

    for (int i = 0; i < 11; i++) begin
      send(tbl[i].name, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      expect_word($sformatf("tbl%0d", i), tbl[i].exp);
    end

    send(5'd4, 5'd5, 5'd0, 5'd0, 32'd2048);
    expect_reject("addi_2048");
    send(5'd9, 5'd0, 5'd1, 5'd2, 32'd3);
    expect_reject("beq_odd");
    send(5'd20, 5'd1, 5'd1, 5'd1, 32'd0);
    expect_reject("name_20");
    check("err_three", {24'b0, err_count}, 32'd3);
    send(5'd11, 5'd1, 5'd0, 5'd0, 32'd1048576);
    expect_reject("jal_range");
    send(5'd10, 5'd0, 5'd1, 5'd2, 32'hFFFF_EFFE);
    expect_reject("bne_range");
    send(5'd12, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF);
    expect_reject("sw_range");
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add_after_rej", 32'h002081B3);

    // Backpressure: a word held for five cycles while the next request waits.
    tick();
    out_ready = 1'b0;
    send(5'd0, 5'd7, 5'd6, 5'd5, 32'd0);
    expect_word("hold_first", 32'h005303B3);
    held = out_instr;
    in_valid = 1'b1; in_name = 5'd1; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
      check($sformatf("hold%0d_valid", c), {31'b0, out_valid}, 32'd1);
      check($sformatf("hold%0d_instr", c), out_instr, held);
    end
    check("hold_enc", {16'b0, enc_count}, {16'b0, exp_enc});
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    expect_word("release_sub", 32'h402081B3);
    tick();
    check("drained", {31'b0, out_valid}, 32'd0);

    // Reset with a word pending.
    out_ready = 1'b0;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("pre_rst", 32'h002081B3);
    rst = 1'b1;
    #1;
    check("rst2_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("rst2_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_err", {24'b0, err_count}, 32'd0);
    check("rst2_enc", {16'b0, enc_count}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    exp_addr = BASE; exp_enc = '0; exp_err = '0;
    #1;
    send(5'd11, 5'd1, 5'd0, 5'd0, 32'd8);
    expect_word("post_rst", 32'h008000EF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
